// File: rtl/osd_dii_pktbuf_pkg.sv
// Shared constants and types for the DII store-and-forward packet buffer.
package osd_dii_pktbuf_pkg;

  // Payload width of one DII flit.
  localparam int DII_DATA_W = 16;

  // Stored entry is {last, data}.
  localparam int FLIT_W = DII_DATA_W + 1;

  // Input-side state: FILL stores flits, DROP swallows the tail of an oversize packet.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_DROP = 1'b1
  } pktbuf_state_e;

endpackage

// File: rtl/osd_dii_flitmem.sv
// Flit storage: one synchronous write port, one asynchronous read port.
module osd_dii_flitmem
  import osd_dii_pktbuf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [FLIT_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [FLIT_W-1:0] rd_data
);

  logic [FLIT_W-1:0] mem_reg [DEPTH];

  // Write one flit per cycle; contents are never reset, pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // Read is combinational so the head flit is visible in the cycle it becomes valid.
  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/osd_dii_pktbuf.sv
// Store-and-forward DII packet buffer: a packet is offered downstream only once
// its last flit is stored; packets larger than the buffer are dropped whole.
module osd_dii_pktbuf
  import osd_dii_pktbuf_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  // upstream (ring side)
  input  logic [DII_DATA_W-1:0]  packet_in_data,
  input  logic                   packet_in_last,
  input  logic                   packet_in_valid,
  output logic                   packet_in_ready,
  // downstream (status/control interface side)
  output logic [DII_DATA_W-1:0]  packet_out_data,
  output logic                   packet_out_last,
  output logic                   packet_out_valid,
  input  logic                   packet_out_ready,
  // status
  output logic [$clog2(DEPTH):0] pkt_count,
  output logic [$clog2(DEPTH):0] free_slots,
  output logic                   overflow,
  output logic [CNT_WIDTH-1:0]   drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;  // extra wrap bit distinguishes full from empty

  pktbuf_state_e        state_reg, state_next;
  logic [PW-1:0]        wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]        rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]        start_ptr_reg, start_ptr_next;
  logic [PW-1:0]        pkt_count_reg, pkt_count_next;
  logic [CNT_WIDTH-1:0] drop_count_reg, drop_count_next;

  logic [PW-1:0]        fill;
  logic                 full;
  logic                 wr_en;
  logic                 commit;
  logic                 drop_trig;
  logic                 pop;
  logic                 pop_last;
  logic [FLIT_W-1:0]    rd_flit;

  assign fill = wr_ptr_reg - rd_ptr_reg;
  assign full = (fill == PW'(DEPTH));

  osd_dii_flitmem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_flitmem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_reg[AW-1:0]),
    .wr_data ({packet_in_last, packet_in_data}),
    .rd_addr (rd_ptr_reg[AW-1:0]),
    .rd_data (rd_flit)
  );

  // Input side: accept/store flits, commit packets, roll back and drop oversize packets.
  always_comb begin
    state_next      = state_reg;
    wr_ptr_next     = wr_ptr_reg;
    start_ptr_next  = start_ptr_reg;
    drop_count_next = drop_count_reg;
    wr_en           = 1'b0;
    commit          = 1'b0;
    drop_trig       = 1'b0;
    packet_in_ready = !full;
    case (state_reg)
      ST_FILL: begin
        if (full && (pkt_count_reg == '0) && packet_in_valid) begin
          // Buffer is entirely one unfinished packet: it can never be forwarded.
          drop_trig       = 1'b1;
          packet_in_ready = 1'b1;
          wr_ptr_next     = start_ptr_reg;
          if (drop_count_reg != '1) begin
            drop_count_next = drop_count_reg + CNT_WIDTH'(1);
          end
          if (!packet_in_last) begin
            state_next = ST_DROP;
          end
        end else if (packet_in_valid && !full) begin
          wr_en       = 1'b1;
          wr_ptr_next = wr_ptr_reg + PW'(1);
          if (packet_in_last) begin
            commit         = 1'b1;
            start_ptr_next = wr_ptr_reg + PW'(1);
          end
        end
      end
      ST_DROP: begin
        packet_in_ready = 1'b1;
        if (packet_in_valid && packet_in_last) begin
          state_next = ST_FILL;
        end
      end
      default: begin
        state_next = ST_FILL;
      end
    endcase
  end

  // Output side: pop the head flit and keep the complete-packet count.
  always_comb begin
    pop            = packet_out_valid && packet_out_ready;
    pop_last       = pop && rd_flit[FLIT_W-1];
    rd_ptr_next    = rd_ptr_reg;
    pkt_count_next = pkt_count_reg;
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PW'(1);
    end
    if (commit && !pop_last) begin
      pkt_count_next = pkt_count_reg + PW'(1);
    end else if (!commit && pop_last) begin
      pkt_count_next = pkt_count_reg - PW'(1);
    end
  end

  // State and pointer registers; reset discards all buffered and partial content.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_FILL;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      start_ptr_reg  <= '0;
      pkt_count_reg  <= '0;
      drop_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      start_ptr_reg  <= start_ptr_next;
      pkt_count_reg  <= pkt_count_next;
      drop_count_reg <= drop_count_next;
    end
  end

  assign packet_out_valid = (pkt_count_reg != '0);
  assign packet_out_data  = rd_flit[DII_DATA_W-1:0];
  assign packet_out_last  = rd_flit[FLIT_W-1];
  assign pkt_count        = pkt_count_reg;
  assign free_slots       = PW'(DEPTH) - fill;
  assign overflow         = drop_trig;
  assign drop_count       = drop_count_reg;

endmodule

// File: tb/tb_osd_dii_pktbuf.sv
// Self-checking bench for osd_dii_pktbuf: per-cycle vector table plus
// hand-written multi-cycle sequences with an expected-flit queue.
module tb_osd_dii_pktbuf;

  localparam int DEPTH     = 16;
  localparam int CNT_WIDTH = 8;
  localparam int PW        = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [15:0]          packet_in_data;
  logic                 packet_in_last;
  logic                 packet_in_valid;
  logic                 packet_in_ready;
  logic [15:0]          packet_out_data;
  logic                 packet_out_last;
  logic                 packet_out_valid;
  logic                 packet_out_ready;
  logic [PW-1:0]        pkt_count;
  logic [PW-1:0]        free_slots;
  logic                 overflow;
  logic [CNT_WIDTH-1:0] drop_count;

  always #5 clk = ~clk;

  osd_dii_pktbuf #(
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .packet_in_data   (packet_in_data),
    .packet_in_last   (packet_in_last),
    .packet_in_valid  (packet_in_valid),
    .packet_in_ready  (packet_in_ready),
    .packet_out_data  (packet_out_data),
    .packet_out_last  (packet_out_last),
    .packet_out_valid (packet_out_valid),
    .packet_out_ready (packet_out_ready),
    .pkt_count        (pkt_count),
    .free_slots       (free_slots),
    .overflow         (overflow),
    .drop_count       (drop_count)
  );

  typedef struct {
    logic        iv;
    logic [15:0] id;
    logic        il;
    logic        ordy;
    logic        e_irdy;
    logic        e_ovld;
    logic [15:0] e_odata;
    logic        e_olast;
    int          e_pkt;
    int          e_free;
    logic        e_ovf;
  } vec_t;

  vec_t        tbl [14];
  int          n_cmp;
  int          n_err;
  logic [16:0] exp_q [$];
  logic        mon_en;
  logic        rnd_rdy;
  logic        in_acc;
  logic        in_rdy_s;
  logic        ovf_s;
  int          ovf_cnt;
  int          ovf_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: sample at the falling edge, then advance past the rising edge.
  task automatic cycle();
    logic [16:0] e;
    @(negedge clk);
    in_rdy_s = packet_in_ready;
    in_acc   = packet_in_valid && packet_in_ready;
    ovf_s    = overflow;
    if (in_acc && overflow) ovf_cnt++;
    if (mon_en && packet_out_valid && packet_out_ready) begin
      if (exp_q.size() == 0) begin
        chk("out_unexpected", {15'd0, packet_out_last, packet_out_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("out_flit", {15'd0, packet_out_last, packet_out_data}, {15'd0, e});
      end
    end
    @(posedge clk);
    #1;
    if (rnd_rdy) packet_out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_flit(input logic [15:0] d, input logic l, input bit keep, output bit ok);
    packet_in_valid = 1'b1;
    packet_in_data  = d;
    packet_in_last  = l;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      cycle();
      if (in_acc) ok = 1'b1;
    end
    if (!ok) chk("in_timeout", 32'd0, 32'd1);
    if (ok && keep) exp_q.push_back({l, d});
    packet_in_valid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [15:0] base, input bit keep, input bit rnd);
    logic [15:0] d;
    bit          ok;
    for (int i = 0; i < len; i++) begin
      d = rnd ? 16'($urandom) : base + 16'(i);
      send_flit(d, (i == len - 1), keep, ok);
      if (ok && ovf_s) ovf_idx = i + 1;
    end
    $display("pkt: len=%0d base=%h keep=%0d pkt_count=%0d free=%0d drops=%0d",
             len, base, keep, pkt_count, free_slots, drop_count);
  endtask

  task automatic drain();
    rnd_rdy          = 1'b0;
    packet_out_ready = 1'b1;
    for (int t = 0; t < 400 && exp_q.size() > 0; t++) cycle();
    chk("drain_empty", exp_q.size(), 32'd0);
    chk("drain_valid", packet_out_valid, 1'b0);
    packet_out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] nxt;
    bit          ok;
    n_cmp = 0; n_err = 0; ovf_cnt = 0; ovf_idx = 0;
    mon_en = 1'b0; rnd_rdy = 1'b0;
    in_acc = 1'b0; in_rdy_s = 1'b0; ovf_s = 1'b0;
    rst = 1'b1;
    packet_in_valid = 1'b0; packet_in_data = '0; packet_in_last = 1'b0;
    packet_out_ready = 1'b0;

    // iv, id, il, ordy | in_ready, out_valid, out_data, out_last, pkt, free, ovf
    // rows 0-6: single 3-flit packet; rows 7-13: commit of B coincides with completion of A
    tbl[0]  = '{1'b1, 16'h0005, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 0, 16, 1'b0};
    tbl[1]  = '{1'b1, 16'h0201, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 0, 15, 1'b0};
    tbl[2]  = '{1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 0, 14, 1'b0};
    tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0005, 1'b0, 1, 13, 1'b0};
    tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0201, 1'b0, 1, 14, 1'b0};
    tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 1, 15, 1'b0};
    tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 0, 16, 1'b0};
    tbl[7]  = '{1'b1, 16'hA000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 0, 16, 1'b0};
    tbl[8]  = '{1'b1, 16'hA001, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 0, 15, 1'b0};
    tbl[9]  = '{1'b1, 16'hB000, 1'b0, 1'b1, 1'b1, 1'b1, 16'hA000, 1'b0, 1, 14, 1'b0};
    tbl[10] = '{1'b1, 16'hB001, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA001, 1'b1, 1, 14, 1'b0};
    tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'hB000, 1'b0, 1, 14, 1'b0};
    tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'hB001, 1'b1, 1, 15, 1'b0};
    tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 0, 16, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_drop_count", drop_count, 32'd0);

    for (int r = 0; r < 14; r++) begin
      packet_in_valid  = tbl[r].iv;
      packet_in_data   = tbl[r].id;
      packet_in_last   = tbl[r].il;
      packet_out_ready = tbl[r].ordy;
      @(negedge clk);
      $display("row %0d: in v=%0d d=%h l=%0d | out v=%0d d=%h l=%0d pkt=%0d free=%0d",
               r, packet_in_valid, packet_in_data, packet_in_last,
               packet_out_valid, packet_out_data, packet_out_last, pkt_count, free_slots);
      chk($sformatf("row%0d_in_ready", r), packet_in_ready, tbl[r].e_irdy);
      chk($sformatf("row%0d_out_valid", r), packet_out_valid, tbl[r].e_ovld);
      chk($sformatf("row%0d_pkt_count", r), pkt_count, tbl[r].e_pkt);
      chk($sformatf("row%0d_free_slots", r), free_slots, tbl[r].e_free);
      chk($sformatf("row%0d_overflow", r), overflow, tbl[r].e_ovf);
      if (tbl[r].e_ovld) begin
        chk($sformatf("row%0d_out_flit", r), {15'd0, packet_out_last, packet_out_data},
            {15'd0, tbl[r].e_olast, tbl[r].e_odata});
      end
      @(posedge clk);
      #1;
    end
    packet_in_valid = 1'b0;
    packet_in_last  = 1'b0;

    // Backpressure: four 4-flit packets fill all 16 slots.
    mon_en = 1'b1;
    packet_out_ready = 1'b0;
    for (int p = 0; p < 4; p++) send_pkt(4, 16'h4000 + 16'(p * 16), 1'b1, 1'b0);
    chk("bp_free_slots", free_slots, 32'd0);
    chk("bp_pkt_count", pkt_count, 32'd4);
    chk("bp_in_ready_full", packet_in_ready, 1'b0);
    packet_in_valid = 1'b1;
    packet_in_data  = 16'h5000;
    packet_in_last  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_hold_ready", in_rdy_s, 1'b0);
    end
    packet_out_ready = 1'b1;
    cycle();
    packet_out_ready = 1'b0;
    cycle();
    chk("bp_resume_accept", in_acc, 1'b1);
    if (in_acc) exp_q.push_back({1'b0, 16'h5000});
    packet_in_valid = 1'b0;
    rnd_rdy = 1'b1;
    for (int i = 1; i < 4; i++) begin
      nxt = 16'h5000 + 16'(i);
      send_flit(nxt, (i == 3), 1'b1, ok);
    end
    drain();

    // Last flit landing in the final free slot commits normally.
    ovf_cnt = 0;
    send_pkt(16, 16'h6000, 1'b1, 1'b0);
    chk("exact_pkt_count", pkt_count, 32'd1);
    chk("exact_free_slots", free_slots, 32'd0);
    chk("exact_no_overflow", ovf_cnt, 32'd0);
    chk("exact_drop_count", drop_count, 32'd0);
    drain();

    // Oversize: 20 flits into an empty buffer; overflow on flit 17.
    ovf_cnt = 0;
    ovf_idx = 0;
    send_pkt(20, 16'h7000, 1'b0, 1'b0);
    chk("ovs_overflow_pulses", ovf_cnt, 32'd1);
    chk("ovs_overflow_flit", ovf_idx, 32'd17);
    chk("ovs_drop_count", drop_count, 32'd1);
    chk("ovs_free_slots", free_slots, 32'd16);
    chk("ovs_pkt_count", pkt_count, 32'd0);
    send_pkt(2, 16'h7100, 1'b1, 1'b0);
    drain();

    // Wrap-around: 50 random packets with random output backpressure.
    rnd_rdy = 1'b1;
    for (int p = 0; p < 50; p++) send_pkt($urandom_range(1, 8), 16'h0000, 1'b1, 1'b1);
    drain();
    chk("wrap_drop_count", drop_count, 32'd1);

    // Reset mid-packet with one complete packet stored.
    mon_en = 1'b0;
    packet_out_ready = 1'b0;
    send_pkt(3, 16'h8000, 1'b0, 1'b0);
    send_flit(16'h8100, 1'b0, 1'b0, ok);
    send_flit(16'h8101, 1'b0, 1'b0, ok);
    chk("rst_pre_pkt_count", pkt_count, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_pkt_count", pkt_count, 32'd0);
    chk("rst_out_valid", packet_out_valid, 1'b0);
    chk("rst_free_slots", free_slots, 32'd16);
    chk("rst_drop_count", drop_count, 32'd0);
    chk("rst_in_ready", packet_in_ready, 1'b1);
    mon_en = 1'b1;
    send_pkt(2, 16'h8200, 1'b1, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
